crot_sequencer: RTL
===================

Name: crot_sequencer

Overview:
Sequences one controlled-phase-rotation (CROT) gate over a 2^NUM_QUBITS complex state vector held in an external amplitude RAM. Only amplitudes whose index has both the control and target bits set change. The block generates exactly those addresses, streams them through an internal ccmult_pipelined instance with a latched twiddle factor, and writes the results back in place. It sits between the QFT top-level gate scheduler and the state-vector RAM.

Parameters:
NUM_QUBITS, 3, number of qubits; RAM depth is 2^NUM_QUBITS; legal range 2..16
QIDX_W, $clog2(NUM_QUBITS) (min 1), width of the qubit index inputs
Data width is TOTAL_WIDTH and fraction width is FRAC_WIDTH, both from the shared fixed-point header (16 / 14 in all examples below, Q2.14).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; sampled only while idle
ctrl_q  in  QIDX_W  control qubit index
tgt_q  in  QIDX_W  target qubit index
tw_re, tw_im  in  TOTAL_WIDTH each  signed twiddle (cos, sin), latched on accepted start
busy  out  1  high from the cycle after start is accepted until the last write completes
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with done on an illegal request
rd_en  out  1  RAM read strobe
rd_addr  out  NUM_QUBITS  RAM read address
rd_re, rd_im  in  TOTAL_WIDTH each  RAM read data, valid exactly 1 cycle after rd_en
wr_en  out  1  RAM write strobe
wr_addr  out  NUM_QUBITS  RAM write address
wr_re, wr_im  out  TOTAL_WIDTH each  write data = amplitude × twiddle

Behaviour:
- Reset: all outputs are 0; FSM in IDLE; valid pipeline cleared; latched twiddle cleared. Reset asserted mid-gate aborts immediately. No further rd_en/wr_en are issued, and no done pulse follows. Partial RAM contents are the caller's problem.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: start=1 with a legal request latches ctrl_q, tgt_q, tw_re and tw_im, clears the issue counter k, and moves to ISSUE.
  - Illegal request: ctrl_q==tgt_q, or either index >= NUM_QUBITS. The block moves to FIN with err set. It issues no reads or writes and never raises busy.
- ISSUE: lasts M = 2^(NUM_QUBITS-2) cycles; rd_en=1 on every one of them.
  - rd_addr is built by expanding k (NUM_QUBITS-2 bits) to a full address: 1s are inserted at bit positions ctrl and tgt, and the k bits fill the remaining positions in ascending order.
  - k increments by 1 per cycle. After the cycle with k=M-1, go to DRAIN.
- Datapath: rd_re/rd_im drive ccmult ar/ai directly; the latched twiddle drives br/bi.
  - ccmult latency is 3, so total rd_en to wr_en latency is 4 cycles.
  - A 4-deep valid/address shift register aligns wr_en and wr_addr with the ccmult output.
  - wr_re = (ar·br − ai·bi) >>> FRAC_WIDTH; wr_im = (ar·bi + ai·br) >>> FRAC_WIDTH. Truncation toward −inf, no saturation; identical to ccmult.
- DRAIN: wait until the valid shift register is empty (4 cycles after the last rd_en), then go to FIN.
- FIN: done=1 (err as latched) for one cycle, then IDLE. busy is low in FIN.
- Timing with start accepted at cycle 0:
  - rd_en in cycles 1..M; wr_en in cycles 5..M+4; done at cycle M+5; busy high in cycles 1..M+4.
  - Illegal request: done=err=1 at cycle 1.
- start while not IDLE is ignored, with no queueing.
- All generated addresses are distinct, so there is no read-after-write hazard. The RAM must support one read and one write per cycle.
- ctrl/tgt ordering is irrelevant: the gate is symmetric.

Decomposition:
- Shared header (existing fixed-point params): TOTAL_WIDTH, FRAC_WIDTH, MULT_WIDTH.
- Shared package/header additions: FSM state encodings (ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FIN) and CCMULT_LATENCY=3. The delay-line depth is CCMULT_LATENCY+1 and must derive from that constant.
- One natural sub-module: crot_addr_expand, a combinational bit-insert of k at (ctrl, tgt), which gets its own unit test.
- The existing ccmult_pipelined is instantiated as-is.

Test Plan:
- N=3, ctrl=0, tgt=2, tw=(0,16384)=i; RAM[5]=(8192,0), RAM[7]=(0,8192). Required: reads of 5 then 7 at cycles 1–2; RAM[5]→(0,8192) and RAM[7]→(−8192,0) at cycles 5–6; done at cycle 7; all other RAM words unchanged.
- N=4, ctrl=1, tgt=3, tw=(16384,0). Required: rd_addr sequence 10,11,14,15; writes return the original data; done at cycle 9.
- Illegal request (ctrl=tgt=1, or ctrl=3 with N=3). Required: done=err=1 at cycle 1; zero rd_en/wr_en; busy never high.
- start re-pulsed during ISSUE and during DRAIN. Required: ignored, and a single done. Back-to-back start in the cycle after done is accepted normally.
- rst_n asserted during the cycle of the 2nd write (N=4). Required: all outputs 0 asynchronously; no further writes; no done; a subsequent start runs a full correct gate.
- Rounding case: amplitude (−1,0) with tw=(8192,0) gives −1·0.5 = −8192/16384 → wr_re=−1 (floor). Random 200-gate sweep against a golden reference model.

Source files
------------

// File: rtl/crot_sequencer_pkg.sv
// Shared fixed-point parameters, FSM encodings and multiplier latency used by
// the CROT sequencer and its complex-multiply datapath.
package crot_sequencer_pkg;

  localparam int TOTAL_WIDTH    = 16;
  localparam int FRAC_WIDTH     = 14;
  localparam int MULT_WIDTH     = 2 * TOTAL_WIDTH;

  localparam int CCMULT_LATENCY = 3;
  // One extra stage covers the RAM's registered read ahead of the multiplier.
  localparam int DLY_DEPTH      = CCMULT_LATENCY + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  typedef logic signed [TOTAL_WIDTH-1:0] sample_t;

  function automatic int qidx_width(input int nq);
    return (nq > 2) ? $clog2(nq) : 1;
  endfunction

endpackage

// File: rtl/ccmult_pipelined.sv
// Three-stage pipelined complex multiplier: p = a * b in fixed point, with the
// product shifted right arithmetically by FRAC_WIDTH and wrapped to TOTAL_WIDTH.
module ccmult_pipelined
  import crot_sequencer_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [TOTAL_WIDTH-1:0] ar,
  input  logic signed [TOTAL_WIDTH-1:0] ai,
  input  logic signed [TOTAL_WIDTH-1:0] br,
  input  logic signed [TOTAL_WIDTH-1:0] bi,
  output logic signed [TOTAL_WIDTH-1:0] pr,
  output logic signed [TOTAL_WIDTH-1:0] pi
);

  sample_t                       r_ar, r_ai, r_br, r_bi;
  logic signed [MULT_WIDTH-1:0]  r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [MULT_WIDTH:0]    w_sum_re, w_sum_im;
  sample_t                       r_pr, r_pi;

  // One guard bit so the sum/difference of two full products cannot overflow.
  assign w_sum_re = $signed({r_p_rr[MULT_WIDTH-1], r_p_rr}) - $signed({r_p_ii[MULT_WIDTH-1], r_p_ii});
  assign w_sum_im = $signed({r_p_ri[MULT_WIDTH-1], r_p_ri}) + $signed({r_p_ir[MULT_WIDTH-1], r_p_ir});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ar   <= '0;
      r_ai   <= '0;
      r_br   <= '0;
      r_bi   <= '0;
      r_p_rr <= '0;
      r_p_ii <= '0;
      r_p_ri <= '0;
      r_p_ir <= '0;
      r_pr   <= '0;
      r_pi   <= '0;
    end else begin
      r_ar   <= ar;
      r_ai   <= ai;
      r_br   <= br;
      r_bi   <= bi;
      r_p_rr <= MULT_WIDTH'(r_ar) * MULT_WIDTH'(r_br);
      r_p_ii <= MULT_WIDTH'(r_ai) * MULT_WIDTH'(r_bi);
      r_p_ri <= MULT_WIDTH'(r_ar) * MULT_WIDTH'(r_bi);
      r_p_ir <= MULT_WIDTH'(r_ai) * MULT_WIDTH'(r_br);
      r_pr   <= TOTAL_WIDTH'(w_sum_re >>> FRAC_WIDTH);
      r_pi   <= TOTAL_WIDTH'(w_sum_im >>> FRAC_WIDTH);
    end
  end

  assign pr = r_pr;
  assign pi = r_pi;

endmodule

// File: rtl/crot_sequencer_addr_expand.sv
// Combinational address builder: inserts 1s at the control and target bit
// positions and spreads the k bits, LSB first, over the remaining positions.
module crot_addr_expand
  import crot_sequencer_pkg::*;
#(
  parameter int NUM_QUBITS = 3,
  parameter int QIDX_W     = qidx_width(NUM_QUBITS),
  parameter int KW         = (NUM_QUBITS > 2) ? NUM_QUBITS - 2 : 1
) (
  input  logic [KW-1:0]         k,
  input  logic [QIDX_W-1:0]     ctrl,
  input  logic [QIDX_W-1:0]     tgt,
  output logic [NUM_QUBITS-1:0] addr
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_QUBITS; gi++) begin : g_bit
      logic       w_hit;
      logic [7:0] w_rank;
      // Rank = how many free positions lie below this bit = which k bit lands here.
      assign w_hit  = (ctrl == QIDX_W'(gi)) || (tgt == QIDX_W'(gi));
      assign w_rank = 8'(gi) - 8'(ctrl < QIDX_W'(gi)) - 8'(tgt < QIDX_W'(gi));
      assign addr[gi] = w_hit ? 1'b1 : |(k & (KW'(1) << w_rank));
    end
  endgenerate

endmodule

// File: rtl/crot_sequencer.sv
// Controlled-phase-rotation sequencer: reads every amplitude with both control
// and target bits set, multiplies it by the latched twiddle and writes it back.
module crot_sequencer
  import crot_sequencer_pkg::*;
#(
  parameter int NUM_QUBITS = 3,
  parameter int QIDX_W     = qidx_width(NUM_QUBITS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [QIDX_W-1:0]             ctrl_q,
  input  logic [QIDX_W-1:0]             tgt_q,
  input  logic signed [TOTAL_WIDTH-1:0] tw_re,
  input  logic signed [TOTAL_WIDTH-1:0] tw_im,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          rd_en,
  output logic [NUM_QUBITS-1:0]         rd_addr,
  input  logic signed [TOTAL_WIDTH-1:0] rd_re,
  input  logic signed [TOTAL_WIDTH-1:0] rd_im,
  output logic                          wr_en,
  output logic [NUM_QUBITS-1:0]         wr_addr,
  output logic signed [TOTAL_WIDTH-1:0] wr_re,
  output logic signed [TOTAL_WIDTH-1:0] wr_im
);

  localparam int              KW     = (NUM_QUBITS > 2) ? NUM_QUBITS - 2 : 1;
  localparam int              M      = 1 << (NUM_QUBITS - 2);
  localparam logic [KW-1:0]   K_LAST = KW'(M - 1);

  state_t                r_state, w_state_next;
  logic [QIDX_W-1:0]     r_ctrl, r_tgt;
  sample_t               r_tw_re, r_tw_im;
  logic [KW-1:0]         r_k;
  logic                  r_err;
  logic [DLY_DEPTH-1:0]  r_vld;
  logic [NUM_QUBITS-1:0] r_addr_dly [DLY_DEPTH];

  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_issue;
  logic [NUM_QUBITS-1:0] w_exp_addr;
  sample_t               w_prod_re, w_prod_im;

  assign w_illegal = (ctrl_q == tgt_q) ||
                     (int'(ctrl_q) >= NUM_QUBITS) ||
                     (int'(tgt_q)  >= NUM_QUBITS);
  assign w_accept  = (r_state == ST_IDLE) && start;

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = w_illegal ? ST_FIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        w_issue = 1'b1;
        busy    = 1'b1;
        if (r_k == K_LAST) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave once only the final delay stage can still hold a write.
        if (r_vld[DLY_DEPTH-2:0] == '0) w_state_next = ST_FIN;
      end
      ST_FIN: begin
        done         = 1'b1;
        err          = r_err;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ctrl  <= '0;
      r_tgt   <= '0;
      r_tw_re <= '0;
      r_tw_im <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_err <= w_illegal;
        r_k   <= '0;
        if (!w_illegal) begin
          r_ctrl  <= ctrl_q;
          r_tgt   <= tgt_q;
          r_tw_re <= tw_re;
          r_tw_im <= tw_im;
        end
      end else if (w_issue) begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  crot_addr_expand #(
    .NUM_QUBITS (NUM_QUBITS),
    .QIDX_W     (QIDX_W),
    .KW         (KW)
  ) u_addr_expand (
    .k    (r_k),
    .ctrl (r_ctrl),
    .tgt  (r_tgt),
    .addr (w_exp_addr)
  );

  assign rd_en   = w_issue;
  assign rd_addr = w_issue ? w_exp_addr : '0;

  // Valid/address delay line matching RAM read latency plus multiplier latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DLY_DEPTH; i++) r_addr_dly[i] <= '0;
    end else begin
      r_vld         <= {r_vld[DLY_DEPTH-2:0], w_issue};
      r_addr_dly[0] <= rd_addr;
      for (int i = 1; i < DLY_DEPTH; i++) r_addr_dly[i] <= r_addr_dly[i-1];
    end
  end

  ccmult_pipelined u_ccmult (
    .clk   (clk),
    .rst_n (rst_n),
    .ar    (rd_re),
    .ai    (rd_im),
    .br    (r_tw_re),
    .bi    (r_tw_im),
    .pr    (w_prod_re),
    .pi    (w_prod_im)
  );

  assign wr_en   = r_vld[DLY_DEPTH-1];
  assign wr_addr = wr_en ? r_addr_dly[DLY_DEPTH-1] : '0;
  assign wr_re   = wr_en ? w_prod_re : '0;
  assign wr_im   = wr_en ? w_prod_im : '0;

endmodule
